// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer.
// The state encoding is used by the FSM in input_debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO  = 2'd0,
        CONFIRM_HI = 2'd1,
        STABLE_HI  = 2'd2,
        CONFIRM_LO = 2'd3
    } state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    function automatic logic is_confirm(input state_e st);
        return (st == CONFIRM_HI) || (st == CONFIRM_LO);
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between the raw input source and the debounced consumer.
interface input_debouncer_if;
    logic din;
    logic dout;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (output din, input dout, input rise_pulse, input fall_pulse, input busy);
    modport slave  (input din, output dout, output rise_pulse, output fall_pulse, output busy);
endinterface

// File: rtl/input_debouncer_sync_chain.sv
// SYNC_STAGES-deep flop chain bringing an asynchronous bit into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift register; stage 0 is the metastability-exposed flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a single-bit input; accepts a level after DEBOUNCE_CYCLES stable samples.
// Optional edge pulses are built only when DEBOUNCE_EDGE_EN is defined (otherwise tied to 0).
module input_debouncer
    import debounce_pkg::*;
#(
    parameter  int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input_debouncer_if.slave   dbus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_s;
    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             dout_s;
    logic             busy_s;
    logic             dout_r;
    logic             busy_r;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dbus.din),
        .q     (sync_s)
    );

    // State and stability counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= STABLE_LO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter logic; a reverted sample always beats confirmation.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            STABLE_LO: begin
                if (sync_s) begin
                    state_s = CONFIRM_HI;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            CONFIRM_HI: begin
                if (!sync_s) begin
                    state_s = STABLE_LO;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = STABLE_HI;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync_s) begin
                    state_s = CONFIRM_LO;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            CONFIRM_LO: begin
                if (sync_s) begin
                    state_s = STABLE_HI;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = STABLE_LO;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = STABLE_LO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Next output values, derived from the transition being taken.
    always_comb begin
        dout_s = dout_r;
        busy_s = is_confirm(state_s);
        if ((state_r == CONFIRM_HI) && (state_s == STABLE_HI)) begin
            dout_s = 1'b1;
        end else if ((state_r == CONFIRM_LO) && (state_s == STABLE_LO)) begin
            dout_s = 1'b0;
        end else begin
            dout_s = dout_r;
        end
    end

    // Registered level and busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            dout_r <= dout_s;
            busy_r <= busy_s;
        end
    end

    assign dbus.dout = dout_r;
    assign dbus.busy = busy_r;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses coincide with the cycle dout changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= dout_s & ~dout_r;
            fall_r <= ~dout_s & dout_r;
        end
    end

    assign dbus.rise_pulse = rise_r;
    assign dbus.fall_pulse = fall_r;
`else
    assign dbus.rise_pulse = 1'b0;
    assign dbus.fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer at default parameters.
// Pulse expectations follow whether DEBOUNCE_EDGE_EN is defined for the build.
module tb_input_debouncer;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    input_debouncer_if dbus ();

    input_debouncer dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (dbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Hold din at lvl for 'hold' edges, then at ~lvl, for 9 edges total.
    task automatic run_case(input string tag, input int hold, input logic lvl);
        logic acc;
        acc = (hold >= 4);
        for (int i = 1; i <= 9; i++) begin
            dbus.din = (i <= hold) ? lvl : ~lvl;
            @(posedge clk);
            #1;
            check_eq($sformatf("%s_dout_e%0d", tag, i), dbus.dout,
                     (acc && (i >= 6)) ? lvl : ~lvl);
            check_eq($sformatf("%s_busy_e%0d", tag, i), dbus.busy,
                     (i >= 3) && (i <= 5) && (i <= hold + 2));
            check_eq($sformatf("%s_rise_e%0d", tag, i), dbus.rise_pulse,
                     EDGE_EN && acc && (i == 6) && lvl);
            check_eq($sformatf("%s_fall_e%0d", tag, i), dbus.fall_pulse,
                     EDGE_EN && acc && (i == 6) && !lvl);
        end
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        dbus.din = 1'b1;
        #3;
        check_eq({tag, "_dout"}, dbus.dout, 1'b0);
        check_eq({tag, "_busy"}, dbus.busy, 1'b0);
        check_eq({tag, "_rise"}, dbus.rise_pulse, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        dbus.din = 1'b1;

        do_reset("rst1");
        run_case("rise", 9, 1'b1);
        run_case("fall", 9, 1'b0);
        run_case("glitch", 2, 1'b1);
        run_case("bound", 3, 1'b1);

        // Abandon a falling candidate by reset while busy.
        run_case("pre_rst", 9, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            dbus.din = 1'b0;
            @(posedge clk);
            #1;
        end
        check_eq("mid_busy", dbus.busy, 1'b1);
        check_eq("mid_dout", dbus.dout, 1'b1);
        reset = 1'b1;
        #2;
        check_eq("async_busy", dbus.busy, 1'b0);
        check_eq("async_dout", dbus.dout, 1'b0);
        check_eq("async_rise", dbus.rise_pulse, 1'b0);
        check_eq("async_fall", dbus.fall_pulse, 1'b0);
        #2;
        reset = 1'b0;
        run_case("post_rst", 9, 1'b1);

        do_reset("rst2");
        run_case("rise2", 9, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
